// File: rtl/hgc_vram_arbiter.sv
// hgc_vram_arbiter: shares the display VRAM between pixel fetch and ISA CPU accesses.
module hgc_vram_arbiter #(
  parameter logic [7:0] MAX_WAIT = 8'd200
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        pixel_read,
  input  logic [18:0] pixel_addr,
  input  logic        isa_op_enable,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_rdy,
  output logic [18:0] ram_a,
  input  logic [7:0]  ram_d,
  output logic [7:0]  ram_dout,
  output logic        ram_we_l,
  output logic        collision,
  output logic [7:0]  wait_cnt
);
  typedef enum logic [2:0] {IDLE, WAIT_SLOT, ACC1, ACC2, DONE} state_t;
  state_t state, state_nx;
  logic [14:0] addr_q;
  logic        we_q;
  logic        acc;
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else state <= state_nx;
  end
  // pixel fetch always wins the slot, even once the starvation limit is hit
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = cpu_req ? WAIT_SLOT : IDLE;
      WAIT_SLOT: state_nx = (!pixel_read && (isa_op_enable || wait_cnt >= MAX_WAIT)) ? ACC1 : WAIT_SLOT;
      ACC1:      state_nx = ACC2;
      ACC2:      state_nx = DONE;
      DONE:      state_nx = cpu_req ? DONE : IDLE;
      default:   state_nx = IDLE;
    endcase
  end
  assign acc      = (state == ACC1) || (state == ACC2);
  assign ram_a    = acc ? {4'b0000, addr_q} : pixel_addr;
  assign ram_we_l = !((state == ACC1) && we_q);
  assign cpu_rdy  = (state == IDLE) || (state == DONE);
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      addr_q    <= '0;
      we_q      <= 1'b0;
      ram_dout  <= '0;
      cpu_dout  <= '0;
      collision <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      if (state == IDLE && cpu_req) begin
        addr_q   <= cpu_addr;
        we_q     <= cpu_we;
        ram_dout <= cpu_din;
        wait_cnt <= '0;
      end
      // count holds when leaving so ACC1 still shows the wait that was spent
      if (state == WAIT_SLOT && state_nx == WAIT_SLOT && wait_cnt != 8'hff) wait_cnt <= wait_cnt + 8'd1;
      if (state == ACC2 && !we_q) cpu_dout <= ram_d;
      if (acc && pixel_read) collision <= 1'b1;
    end
  end
endmodule
